// File: rtl/count_checker.sv
// count_checker: passive observer for a WIDTH-bit loadable up/down counter.
//
// Every enabled cycle the checker samples the counter's control inputs and
// its count. From these it predicts the count the counter must show on the
// next cycle. While armed, it compares the observed count with the previous
// prediction. A difference raises a one-cycle mismatch pulse and increments
// a saturating error counter. The checker goes to a sticky fault state when
// that counter reaches ERR_LIMIT.
//
// Ports:
//   clock          system clock, rising edge
//   reset          synchronous, active-high
//   mon_en         sample qualifier (0 = ignore this cycle)
//   obs_resetn     counter's active-low reset as seen by the counter
//   obs_load       counter load input
//   obs_din        counter load data
//   obs_up_down    counter direction (0 up, 1 down)
//   obs_count      counter output
//   clr_err        clears err_count, first_err_* and fault
//   expected       registered prediction for the current obs_count
//   pred_valid     expected is meaningful this cycle
//   mismatch       one-cycle pulse, obs_count differed from expected
//   err_count      saturating mismatch count
//   first_err_exp  expected value at the first mismatch
//   first_err_obs  observed value at the first mismatch
//   fault          high while in the FAULT state
//
// Optional build macro COUNT_CHECKER_COVERAGE_EN adds up_wrap_cnt and
// down_reload_cnt. These count matching compares of up-wraps and of
// down-reloads.
module count_checker #(
  parameter int WIDTH     = 4,
  parameter int LOW       = 2,
  parameter int HIGH      = 10,
  parameter int ERR_W     = 8,
  parameter int ERR_LIMIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mon_en,
  input  logic             obs_resetn,
  input  logic             obs_load,
  input  logic [WIDTH-1:0] obs_din,
  input  logic             obs_up_down,
  input  logic [WIDTH-1:0] obs_count,
  input  logic             clr_err,
  output logic [WIDTH-1:0] expected,
  output logic             pred_valid,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_obs,
`ifdef COUNT_CHECKER_COVERAGE_EN
  output logic [7:0]       up_wrap_cnt,
  output logic [7:0]       down_reload_cnt,
`endif
  output logic             fault
);

  localparam logic [WIDTH-1:0] LOW_V   = WIDTH'(LOW);
  localparam logic [WIDTH-1:0] HIGH_V  = WIDTH'(HIGH);
  localparam logic [ERR_W-1:0] LIMIT_V = ERR_W'(ERR_LIMIT);

  typedef enum logic [1:0] {UNSYNC, ARMED, FAULT} state_t;

  state_t state, state_nxt;

  function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [WIDTH-1:0] pred_p0;
  logic             cmp_p0;
  logic             miss_p0;
  logic [ERR_W-1:0] err_nxt_p0;
  logic             limit_hit_p0;

  // ---- stage p0: prediction from this cycle's sample, compare against the
  // ---- prediction made one cycle earlier
  always_comb begin
    pred_p0 = '0;
    if (!obs_resetn) begin
      pred_p0 = '0;
    end else if (obs_load) begin
      pred_p0 = obs_din;
    end else if (!obs_up_down) begin
      pred_p0 = (obs_count > HIGH_V) ? '0 : obs_count + 1'b1;
    end else begin
      pred_p0 = ((obs_count > HIGH_V) || (obs_count < LOW_V)) ? HIGH_V
                                                             : obs_count - 1'b1;
    end
  end

  // A compare needs a live prediction; pred_valid drops after any disabled
  // cycle, so the first sample after re-enable only predicts.
  assign cmp_p0  = mon_en & pred_valid;
  assign miss_p0 = cmp_p0 & (obs_count != expected);

  // clr_err wins over a same-cycle mismatch.
  assign err_nxt_p0   = clr_err ? '0 : (miss_p0 ? sat_inc_err(err_count) : err_count);
  assign limit_hit_p0 = ~clr_err & miss_p0 & (err_nxt_p0 >= LIMIT_V);

  always_comb begin
    state_nxt = state;
    case (state)
      UNSYNC: begin
        if (mon_en) state_nxt = ARMED;
      end
      ARMED: begin
        if (!mon_en)           state_nxt = UNSYNC;
        else if (limit_hit_p0) state_nxt = FAULT;
      end
      FAULT: begin
        if (clr_err) state_nxt = mon_en ? ARMED : UNSYNC;
      end
      default: state_nxt = UNSYNC;
    endcase
  end

  // ---- stage p1: registered prediction, flags and statistics
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= UNSYNC;
      expected      <= '0;
      pred_valid    <= 1'b0;
      mismatch      <= 1'b0;
      err_count     <= '0;
      first_err_exp <= '0;
      first_err_obs <= '0;
    end else begin
      state      <= state_nxt;
      pred_valid <= mon_en;
      mismatch   <= miss_p0;
      err_count  <= err_nxt_p0;
      if (mon_en) expected <= pred_p0;
      if (clr_err) begin
        first_err_exp <= '0;
        first_err_obs <= '0;
      end else if (miss_p0 && (err_count == '0)) begin
        first_err_exp <= expected;
        first_err_obs <= obs_count;
      end
    end
  end

  assign fault = (state == FAULT);

`ifdef COUNT_CHECKER_COVERAGE_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic wrap_p0, reload_p0;
  logic wrap_p1, reload_p1;

  assign wrap_p0   = obs_resetn & ~obs_load & ~obs_up_down & (obs_count > HIGH_V);
  assign reload_p0 = obs_resetn & ~obs_load & obs_up_down &
                     ((obs_count > HIGH_V) | (obs_count < LOW_V));

  // ---- stage p1: the wrap/reload tag travels with the prediction it produced
  always_ff @(posedge clock) begin
    if (reset) begin
      wrap_p1         <= 1'b0;
      reload_p1       <= 1'b0;
      up_wrap_cnt     <= '0;
      down_reload_cnt <= '0;
    end else begin
      if (mon_en) begin
        wrap_p1   <= wrap_p0;
        reload_p1 <= reload_p0;
      end
      if (clr_err) begin
        up_wrap_cnt     <= '0;
        down_reload_cnt <= '0;
      end else if (cmp_p0 && !miss_p0) begin
        if (wrap_p1)   up_wrap_cnt     <= sat_inc8(up_wrap_cnt);
        if (reload_p1) down_reload_cnt <= sat_inc8(down_reload_cnt);
      end
    end
  end
`endif

endmodule
